// File: rtl/cnn_sequencer_if.sv
// Handshake bundle between the inference sequencer and the
// conv/relu/pool/fc datapath plus the class-score mux.
interface cnn_sequencer_if #(
  parameter int PROB_W = 32
);
  logic              start;
  logic              conv_done;
  logic              relu_done;
  logic              pool_done;
  logic              fc_done;
  logic [PROB_W-1:0] prob_in;
  logic              conv_enable;
  logic              relu_enable;
  logic              pool_enable;
  logic              fc_enable;
  logic [3:0]        prob_sel;
  logic              busy;
  logic [3:0]        result;
  logic              result_valid;
  logic              timeout_err;
  logic [1:0]        err_stage;

  modport master (
    input  start, conv_done, relu_done,
    input  pool_done, fc_done, prob_in,
    output conv_enable, relu_enable,
    output pool_enable, fc_enable,
    output prob_sel, busy, result,
    output result_valid, timeout_err,
    output err_stage
  );

  modport slave (
    output start, conv_done, relu_done,
    output pool_done, fc_done, prob_in,
    input  conv_enable, relu_enable,
    input  pool_enable, fc_enable,
    input  prob_sel, busy, result,
    input  result_valid, timeout_err,
    input  err_stage
  );
endinterface

// File: rtl/cnn_sequencer.sv
// Inference controller: steps conv->relu->pool->fc under a
// watchdog, then scans the class scores for the argmax.
module cnn_sequencer #(
  parameter int PROB_W    = 32,
  parameter int NUM_CLASS = 10,
  parameter int TIMEOUT   = 4096
) (
  input logic           clk,
  input logic           rst,
  cnn_sequencer_if.master bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [3:0] SEL_LAST = 4'(NUM_CLASS - 1);

  typedef enum logic [2:0] {
    IDLE, CONV, RELU, POOL, FC, ARGMAX, DONE, ERR
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]            cnt_q;
  logic [3:0]               sel_q;
  logic [3:0]               best_idx_q;
  logic [3:0]               result_q;
  logic signed [PROB_W-1:0] best_q;
  logic conv_en_q, relu_en_q;
  logic pool_en_q, fc_en_q;
  logic busy_q, rv_q, terr_q;
  logic [1:0] es_q;

  logic       in_stage;
  logic       stage_done;
  logic [1:0] stage_idx;
  logic       accept;
  logic       wd_fire;

  always_comb begin
    in_stage   = 1'b0;
    stage_done = 1'b0;
    stage_idx  = 2'd0;
    unique case (state_q)
      CONV: begin
        in_stage   = 1'b1;
        stage_done = bus.conv_done;
        stage_idx  = 2'd0;
      end
      RELU: begin
        in_stage   = 1'b1;
        stage_done = bus.relu_done;
        stage_idx  = 2'd1;
      end
      POOL: begin
        in_stage   = 1'b1;
        stage_done = bus.pool_done;
        stage_idx  = 2'd2;
      end
      FC: begin
        in_stage   = 1'b1;
        stage_done = bus.fc_done;
        stage_idx  = 2'd3;
      end
      default: ;
    endcase
  end

  assign accept = bus.start &&
    (state_q == IDLE || state_q == ERR);
  // A done on the last allowed cycle still wins.
  assign wd_fire = in_stage && !stage_done &&
    (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ERR: if (bus.start) state_d = CONV;
      CONV:
        if (stage_done)   state_d = RELU;
        else if (wd_fire) state_d = ERR;
      RELU:
        if (stage_done)   state_d = POOL;
        else if (wd_fire) state_d = ERR;
      POOL:
        if (stage_done)   state_d = FC;
        else if (wd_fire) state_d = ERR;
      FC:
        if (stage_done)   state_d = ARGMAX;
        else if (wd_fire) state_d = ERR;
      ARGMAX:
        if (sel_q == SEL_LAST) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      result_q   <= '0;
      conv_en_q  <= 1'b0;
      relu_en_q  <= 1'b0;
      pool_en_q  <= 1'b0;
      fc_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      terr_q     <= 1'b0;
      es_q       <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= (in_stage && state_d == state_q) ?
        cnt_q + 1'b1 : '0;
      conv_en_q <= (state_d == CONV);
      relu_en_q <= (state_d == RELU);
      pool_en_q <= (state_d == POOL);
      fc_en_q   <= (state_d == FC);
      busy_q <= !(state_d == IDLE || state_d == ERR);
      sel_q <= (state_q == ARGMAX && state_d == ARGMAX) ?
        sel_q + 4'd1 : 4'd0;
      // Strict compare keeps the lowest index on ties.
      if (state_q == ARGMAX &&
          (sel_q == 4'd0 || $signed(bus.prob_in) > best_q)) begin
        best_q     <= $signed(bus.prob_in);
        best_idx_q <= sel_q;
      end
      rv_q <= (state_q == DONE);
      if (state_q == DONE)
        result_q <= best_idx_q;
      else if (accept)
        result_q <= 4'd0;
      if (accept) begin
        terr_q <= 1'b0;
        es_q   <= 2'd0;
      end else if (wd_fire) begin
        terr_q <= 1'b1;
        es_q   <= stage_idx;
      end
    end
  end

  assign bus.conv_enable  = conv_en_q;
  assign bus.relu_enable  = relu_en_q;
  assign bus.pool_enable  = pool_en_q;
  assign bus.fc_enable    = fc_en_q;
  assign bus.prob_sel     = sel_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.timeout_err  = terr_q;
  assign bus.err_stage    = es_q;
endmodule
